// File: rtl/trace_pkg.sv
// trace_pkg: shared types and defaults for the pc_trace_buffer capture block.
package trace_pkg;

  localparam int unsigned TRACE_XLEN_DEF  = 32;
  localparam int unsigned TRACE_DEPTH_DEF = 16;
  localparam int unsigned TSTAMP_W        = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: Depth x Width register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module trace_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 64,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Synchronous write of one entry.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: circular trace capture of CH x XLEN samples. After a trigger a
// clamped number of further samples is recorded, then the buffer freezes and is
// streamed out oldest-first over valid/ready.
// Optional feature macro: PC_TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter stored with every entry and presented on rd_tstamp.
module pc_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned XLEN  = TRACE_XLEN_DEF,
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF,
  localparam int unsigned PW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                trig,
  input  logic                smp_valid,
  input  logic [CH*XLEN-1:0]  smp_data,
  input  logic [PW-1:0]       post_cnt,
  output logic [2:0]          state_o,
  output logic                done,
  output logic                wrapped,
  output logic [PW-1:0]       count,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [CH*XLEN-1:0]  rd_data,
  output logic                rd_last
`ifdef PC_TRACE_TIMESTAMP_EN
  ,
  output logic [TSTAMP_W-1:0] rd_tstamp
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = CH * XLEN;
`ifdef PC_TRACE_TIMESTAMP_EN
  localparam int unsigned MW = DW + TSTAMP_W;
`else
  localparam int unsigned MW = DW;
`endif

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [PW-1:0] rd_left_q, rd_left_d;
  logic          wrapped_q, wrapped_d;

  logic          we;
  logic          xfer;
  logic [PW-1:0] rem_lat;
  logic [MW-1:0] ram_wdata;
  logic [MW-1:0] ram_rdata;

  // Clamp so the trigger sample itself is never overwritten.
  assign rem_lat = (post_cnt > PW'(DEPTH - 1)) ? PW'(DEPTH - 1) : post_cnt;

  // arm aborts everything, including a write in the same cycle.
  assign we   = smp_valid && !arm && ((state_q == ARMED) || (state_q == POST));
  assign xfer = rd_valid && rd_ready && !arm;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (trig) state_d = (rem_lat == '0) ? DONE : POST;
        POST:    if (we && (rem_q == PW'(1))) state_d = DONE;
        DONE:    if (xfer && (rd_left_q == PW'(1))) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; rd_data is forced to zero whenever no entry is offered.
  always_comb begin
    state_o  = state_q;
    done     = (state_q == DONE);
    rd_valid = done && (rd_left_q != '0);
    rd_last  = rd_valid && (rd_left_q == PW'(1));
    rd_data  = rd_valid ? ram_rdata[DW-1:0] : '0;
  end

  // Datapath next-state: pointers, fill count, post-trigger budget, readout budget.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rem_d     = rem_q;
    rd_left_d = rd_left_q;
    wrapped_d = wrapped_q;
    if (arm) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rem_d     = '0;
      rd_left_d = '0;
      wrapped_d = 1'b0;
    end else begin
      if (we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == PW'(DEPTH)) begin
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      if ((state_q == ARMED) && trig) begin
        rem_d = rem_lat;
      end else if ((state_q == POST) && we) begin
        rem_d = rem_q - 1'b1;
      end
      // On entry to DONE the oldest entry sits at wr_ptr once the buffer has wrapped.
      if ((state_d == DONE) && (state_q != DONE)) begin
        rd_ptr_d  = wrapped_d ? wr_ptr_d : '0;
        rd_left_d = count_d;
      end
      if (xfer) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_left_d = rd_left_q - 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      rd_left_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      rd_left_q <= rd_left_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;

`ifdef PC_TRACE_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_q;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + 1'b1;
    end
  end

  assign ram_wdata = {tstamp_q, smp_data};
  assign rd_tstamp = rd_valid ? ram_rdata[MW-1:DW] : '0;
`else
  assign ram_wdata = smp_data;
`endif

  trace_ram #(
    .Depth (DEPTH),
    .Width (MW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: directed scenarios plus randomized captures against a
// queue-based reference model of the trace buffer.
module tb_pc_trace_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CH    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = $clog2(DEPTH + 1);
  localparam int unsigned DW    = XLEN * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          smp_valid = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic [PW-1:0] post_cnt = '0;
  logic          rd_ready = 1'b0;
  logic [2:0]    state_o;
  logic          done, wrapped, rd_valid, rd_last;
  logic [PW-1:0] count;
  logic [DW-1:0] rd_data;
`ifdef PC_TRACE_TIMESTAMP_EN
  logic [31:0]   rd_tstamp;
  logic [31:0]   cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: every sample written since arm, in order.
  int            m_phase;  // 0 idle, 1 armed, 2 post, 3 done
  int            m_rem;
  logic [DW-1:0] m_q[$];
  logic [31:0]   m_ts[$];

  always #5 clk = ~clk;

`ifdef PC_TRACE_TIMESTAMP_EN
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 1;
  end
`endif

  pc_trace_buffer #(
    .XLEN  (XLEN),
    .CH    (CH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig      (trig),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .post_cnt  (post_cnt),
    .state_o   (state_o),
    .done      (done),
    .wrapped   (wrapped),
    .count     (count),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last)
`ifdef PC_TRACE_TIMESTAMP_EN
    ,
    .rd_tstamp (rd_tstamp)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    return (m_q.size() > int'(DEPTH)) ? int'(DEPTH) : m_q.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [DW-1:0] d);
    m_q.push_back(d);
`ifdef PC_TRACE_TIMESTAMP_EN
    m_ts.push_back(cyc);
`else
    m_ts.push_back(32'd0);
`endif
  endtask

  // Applies the capture rules for one clock edge (no arm, no reset).
  task automatic model_edge(input logic v, input logic t, input logic [DW-1:0] d);
    if (m_phase == 1) begin
      if (v) model_push(d);
      if (t) begin
        m_rem   = (int'(post_cnt) > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : int'(post_cnt);
        m_phase = (m_rem == 0) ? 3 : 2;
      end
    end else if (m_phase == 2 && v) begin
      model_push(d);
      m_rem--;
      if (m_rem == 0) m_phase = 3;
    end
  endtask

  task automatic drive(input logic v, input logic t, input logic [DW-1:0] d);
    smp_valid = v;
    trig      = t;
    smp_data  = d;
    model_edge(v, t, d);
    step();
    smp_valid = 1'b0;
    trig      = 1'b0;
    check_eq("state", 64'(state_o), 64'(m_phase));
    check_eq("count", 64'(count), 64'(m_count()));
    check_eq("wrapped", 64'(wrapped), 64'(m_q.size() > int'(DEPTH)));
    check_eq("done", 64'(done), 64'(m_phase == 3));
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    m_q.delete();
    m_ts.delete();
    m_phase = 1;
    check_eq("arm_state", 64'(state_o), 64'(1));
    check_eq("arm_count", 64'(count), 64'(0));
    check_eq("arm_wrapped", 64'(wrapped), 64'(0));
    check_eq("arm_rd_valid", 64'(rd_valid), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_q.delete();
    m_ts.delete();
    m_phase = 0;
    check_eq("rst_state", 64'(state_o), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_wrapped", 64'(wrapped), 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_rd_valid", 64'(rd_valid), 64'(0));
    check_eq("rst_rd_last", 64'(rd_last), 64'(0));
    check_eq("rst_rd_data", 64'(rd_data), 64'(0));
  endtask

  // mode 0: always ready, 1: ready 1,0,1,0..., 2: random ready. Stops after limit transfers.
  task automatic readout(input int mode, input int limit);
    int n      = m_count();
    int base   = m_q.size() - n;
    int idx    = 0;
    int budget = 8 * n + 20;
    int want   = (limit < n) ? limit : n;
    logic          tog = 1'b1;
    logic          stalled = 1'b0;
    logic [DW-1:0] sd = '0;
    logic          sl = 1'b0;
    if (n == 0) begin
      for (int k = 0; k < 3; k++) begin
        rd_ready = 1'b1;
        step();
        check_eq("empty_rd_valid", 64'(rd_valid), 64'(0));
        check_eq("empty_done", 64'(done), 64'(1));
      end
      rd_ready = 1'b0;
      return;
    end
    while (idx < want && budget > 0) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       begin rd_ready = tog; tog = ~tog; end
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check_eq("stall_valid", 64'(rd_valid), 64'(1));
        check_eq("stall_data", 64'(rd_data), 64'(sd));
        check_eq("stall_last", 64'(rd_last), 64'(sl));
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          check_eq("rd_data", 64'(rd_data), 64'(m_q[base+idx]));
          check_eq("rd_last", 64'(rd_last), 64'(idx == n - 1));
`ifdef PC_TRACE_TIMESTAMP_EN
          check_eq("rd_tstamp", 64'(rd_tstamp), 64'(m_ts[base+idx]));
`endif
          idx++;
        end else begin
          stalled = 1'b1;
          sd = rd_data;
          sl = rd_last;
        end
      end
      step();
      budget--;
    end
    rd_ready = 1'b0;
    check_eq("rd_xfers", 64'(idx), 64'(want));
    if (idx == n) begin
      m_phase = 0;
      check_eq("end_state", 64'(state_o), 64'(0));
      check_eq("end_done", 64'(done), 64'(0));
      check_eq("end_rd_valid", 64'(rd_valid), 64'(0));
    end
  endtask

  function automatic logic [DW-1:0] mk(input int ch0);
    return {32'($urandom), 32'(ch0)};
  endfunction

  // Basic capture: ch0 = 0,4,8(trig),12,16 with post_cnt = 2.
  task automatic scen_basic();
    post_cnt = PW'(2);
    do_arm();
    for (int k = 0; k < 5; k++) drive(1'b1, k == 2, mk(4 * k));
    check_eq("basic_count", 64'(count), 64'(5));
  endtask

  initial begin
    m_phase = 0;
    repeat (3) step();
    do_reset();

    scen_basic();
    readout(0, 100);

    // Wrap with immediate stop.
    post_cnt = '0;
    do_arm();
    for (int k = 0; k < 12; k++) drive(1'b1, k == 11, mk(4 * k));
    check_eq("wrap_flag", 64'(wrapped), 64'(1));
    check_eq("wrap_first", 64'(rd_data[31:0]), 64'(16));
    readout(0, 100);

    // Backpressure.
    scen_basic();
    readout(1, 100);

    // Clamp: post_cnt beyond DEPTH-1 keeps the trigger sample as oldest entry.
    post_cnt = PW'(15);
    do_arm();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, mk(100 + k));
    drive(1'b1, 1'b1, mk(200));
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, mk(300 + k));
    check_eq("clamp_first", 64'(rd_data[31:0]), 64'(200));
    readout(2, 100);

    // Re-arm during POST.
    post_cnt = PW'(5);
    do_arm();
    drive(1'b1, 1'b0, mk(1));
    drive(1'b1, 1'b1, mk(2));
    drive(1'b1, 1'b0, mk(3));
    do_arm();

    // Trigger without samples and no post window: DONE with nothing to read.
    post_cnt = '0;
    do_arm();
    drive(1'b0, 1'b1, mk(0));
    readout(0, 100);

    // Reset mid-readout.
    scen_basic();
    readout(0, 2);
    do_reset();

    // Randomized captures.
    for (int r = 0; r < 12; r++) begin
      int guard = 0;
      post_cnt = PW'($urandom_range(0, 15));
      do_arm();
      for (int k = $urandom_range(0, 12); k > 0; k--)
        drive(1'($urandom_range(0, 3) != 0), 1'b0, mk($urandom));
      drive(1'($urandom_range(0, 1)), 1'b1, mk($urandom));
      while (m_phase != 3 && guard < 80) begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), mk($urandom));
        guard++;
      end
      check_eq("rand_reached_done", 64'(m_phase == 3), 64'(1));
      readout(int'($urandom_range(0, 2)), 100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
